// File: rtl/gate_selftest_driver_if.sv
// Bus between the self-test driver and the gate-select block.
// The driver owns a/b/sel; the gate block returns y_in.
interface gate_selftest_driver_if;
  logic       a;
  logic       b;
  logic [5:0] sel;
  logic       y_in;

  modport master (
    output a,
    output b,
    output sel,
    input  y_in
  );

  modport slave (
    input  a,
    input  b,
    input  sel,
    output y_in
  );
endinterface

// File: rtl/gate_selftest_driver.sv
// Self-test initiator for the gate-select block: walks 25 vectors,
// compares the block's output and reports a per-gate fail mask.
module gate_selftest_driver #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  gate_selftest_driver_if.master gbus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [6:0]            fail_mask
);

  localparam int CW =
    (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);
  localparam logic [4:0]    LAST    = 5'd24;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_q, a_d;
  logic          b_q, b_d;
  logic [5:0]    sel_q, sel_d;
  logic          busy_d, done_d, pass_d;
  logic [6:0]    mask_d;

  // Returns {a, b, sel}; vector 0 is the null vector.
  function automatic logic [7:0] vec_drive(input logic [4:0] idx);
    logic [4:0] k;
    logic [7:0] r;
    k = idx - 5'd1;
    if (idx == 5'd0) r = {2'b11, 6'b0};
    else r = {k[1:0], 6'(6'b1 << k[4:2])};
    return r;
  endfunction

  logic [7:0] cur;
  logic [7:0] nxt;
  logic       cur_a, cur_b;
  logic [5:0] cur_sel;
  logic       exp_y;
  logic [6:0] bit_m;
  logic [6:0] hit;

  assign cur     = vec_drive(vec_q);
  assign nxt     = vec_drive(5'(vec_q + 5'd1));
  assign cur_a   = cur[7];
  assign cur_b   = cur[6];
  assign cur_sel = cur[5:0];
  assign bit_m   = (vec_q == 5'd0) ? 7'h40 : {1'b0, cur_sel};

  always_comb begin
    exp_y = 1'b0;
    unique case (1'b1)
      cur_sel[0]: exp_y = cur_a & cur_b;
      cur_sel[1]: exp_y = cur_a | cur_b;
      cur_sel[2]: exp_y = ~(cur_a & cur_b);
      cur_sel[3]: exp_y = ~(cur_a | cur_b);
      cur_sel[4]: exp_y = cur_a ^ cur_b;
      cur_sel[5]: exp_y = ~(cur_a ^ cur_b);
      default:    exp_y = 1'b0;
    endcase
  end

  assign hit = fail_mask | ((gbus.y_in != exp_y) ? bit_m : 7'h00);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    busy_d  = busy;
    done_d  = 1'b0;
    pass_d  = pass;
    mask_d  = fail_mask;
    unique case (state_q)
      IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        sel_d  = 6'd0;
        busy_d = 1'b0;
        if (start) begin
          state_d = APPLY;
          vec_d   = 5'd0;
          cnt_d   = '0;
          {a_d, b_d, sel_d} = vec_drive(5'd0);
          busy_d  = 1'b1;
          mask_d  = 7'h00;
          pass_d  = 1'b0;
        end
      end
      APPLY: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_MAX) begin
          mask_d = hit;
          cnt_d  = '0;
          if (vec_q == LAST) begin
            state_d = FINISH;
            a_d     = 1'b0;
            b_d     = 1'b0;
            sel_d   = 6'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (hit == 7'h00);
          end else begin
            vec_d = 5'(vec_q + 5'd1);
            {a_d, b_d, sel_d} = nxt;
          end
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_q     <= 5'd0;
      cnt_q     <= '0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      sel_q     <= 6'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 7'h00;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      fail_mask <= mask_d;
    end
  end

  assign gbus.a   = a_q;
  assign gbus.b   = b_q;
  assign gbus.sel = sel_q;

endmodule

// File: tb/tb_gate_selftest_driver.sv
// Bench for gate_selftest_driver: table of gate-block behaviours,
// random fault injection against a reference, reset and timing cases.
module tb_gate_selftest_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start0 = 1'b0;

  logic       busy, done, pass;
  logic [6:0] fail_mask;
  logic       busy0, done0, pass0;
  logic [6:0] fail_mask0;

  gate_selftest_driver_if gif ();
  gate_selftest_driver_if gif0 ();

  gate_selftest_driver #(.SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .gbus      (gif.master),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask)
  );

  gate_selftest_driver #(.SETTLE_CYCLES(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start0),
    .gbus      (gif0.master),
    .busy      (busy0),
    .done      (done0),
    .pass      (pass0),
    .fail_mask (fail_mask0)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // 0 ideal, 1 tied 0, 2 tied 1, 3 AND acts as OR, 4 random flips
  int          mode = 0;
  logic [24:0] flip = '0;

  function automatic logic gate_ref(
    input logic a, input logic b,
    input logic [5:0] sel, input logic or_fault
  );
    if (sel[0]) return or_fault ? (a | b) : (a & b);
    if (sel[1]) return a | b;
    if (sel[2]) return ~(a & b);
    if (sel[3]) return ~(a | b);
    if (sel[4]) return a ^ b;
    if (sel[5]) return ~(a ^ b);
    return 1'b0;
  endfunction

  function automatic int vec_of(
    input logic a, input logic b, input logic [5:0] sel
  );
    for (int g = 0; g < 6; g++)
      if (sel[g]) return 1 + 4 * g + 2 * int'(a) + int'(b);
    return 0;
  endfunction

  function automatic logic [6:0] ref_mask(input logic [24:0] f);
    logic [6:0] m;
    m = '0;
    for (int v = 0; v < 25; v++)
      if (f[v]) begin
        if (v == 0) m[6] = 1'b1;
        else m[(v - 1) / 4] = 1'b1;
      end
    return m;
  endfunction

  always @(posedge clk) begin
    logic yv;
    yv = gate_ref(gif.a, gif.b, gif.sel, 1'b0);
    case (mode)
      1: gif.y_in <= 1'b0;
      2: gif.y_in <= 1'b1;
      3: gif.y_in <= gate_ref(gif.a, gif.b, gif.sel, 1'b1);
      4: gif.y_in <= yv ^ flip[vec_of(gif.a, gif.b, gif.sel)];
      default: gif.y_in <= yv;
    endcase
  end

  assign gif0.y_in = gate_ref(gif0.a, gif0.b, gif0.sel, 1'b0);

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (!$onehot0(gif.sel) || !$onehot0(gif0.sel)) begin
        bad++;
        $display("FAIL sel_onehot: got %b/%b want zero-or-one-hot",
                 gif.sel, gif0.sel);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run(input bit z, input bit poke,
                     output int bcnt, output int dcnt,
                     output logic [6:0] m, output logic p,
                     output bit to);
    if (z) start0 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    if (z) start0 = 1'b0; else start = 1'b0;
    bcnt = 0; dcnt = 0; to = 1'b1; m = '0; p = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (poke && i == 10) start0 = 1'b1;
      if (poke && i == 11) start0 = 1'b0;
      if (z ? busy0 : busy) bcnt++;
      if (z ? done0 : done) begin
        dcnt++;
        m  = z ? fail_mask0 : fail_mask;
        p  = z ? pass0 : pass;
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (z ? done0 : done) dcnt++;
  endtask

  typedef struct {
    int         md;
    logic [6:0] mask;
    logic       ok;
    string      nm;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int bc, dc;
    logic [6:0] m;
    logic p;
    bit to;
    int t0, n;
    int tdone[3];

    tbl[0] = '{0, 7'h00, 1'b1, "ideal"};
    tbl[1] = '{1, 7'h3F, 1'b0, "tie0"};
    tbl[2] = '{2, 7'h7F, 1'b0, "tie1"};
    tbl[3] = '{3, 7'h01, 1'b0, "and_as_or"};

    #12;
    chk("rst_outputs", {gif.a, gif.b, gif.sel, busy, done, pass,
                        fail_mask}, 0);
    chk("rst_outputs0", {gif0.a, gif0.b, gif0.sel, busy0, done0,
                         pass0, fail_mask0}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].md;
      run(1'b0, 1'b0, bc, dc, m, p, to);
      chk({tbl[i].nm, "_timeout"}, 32'(to), 0);
      chk({tbl[i].nm, "_busy_len"}, bc, 75);
      chk({tbl[i].nm, "_done_cnt"}, dc, 1);
      chk({tbl[i].nm, "_mask"}, 32'(m), 32'(tbl[i].mask));
      chk({tbl[i].nm, "_pass"}, 32'(p), 32'(tbl[i].ok));
      repeat (3) @(posedge clk);
      #1;
      chk({tbl[i].nm, "_mask_hold"}, 32'(fail_mask),
          32'(tbl[i].mask));
    end

    for (int r = 0; r < 4; r++) begin
      mode = 4;
      flip = 25'($urandom & $urandom & $urandom);
      if (r == 0) flip = '0;
      run(1'b0, 1'b0, bc, dc, m, p, to);
      chk("rand_busy_len", bc, 75);
      chk("rand_mask", 32'(m), 32'(ref_mask(flip)));
      chk("rand_pass", 32'(p), 32'(ref_mask(flip) == 7'h00));
    end

    // Asynchronous reset in the middle of vector 10.
    mode = 2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (vec_of(gif.a, gif.b, gif.sel) != 10 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_vec10", 32'(n < 200), 1);
    chk("mask_before_rst", 32'(fail_mask), 32'h43);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst", {gif.a, gif.b, gif.sel, busy, fail_mask}, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    mode = 0;
    run(1'b0, 1'b0, bc, dc, m, p, to);
    chk("post_rst_busy_len", bc, 75);
    chk("post_rst_pass", 32'(p), 1);
    chk("post_rst_mask", 32'(m), 0);

    // Zero settle cycles, with start poked while busy.
    run(1'b1, 1'b1, bc, dc, m, p, to);
    chk("s0_timeout", 32'(to), 0);
    chk("s0_busy_len", bc, 25);
    chk("s0_done_cnt", dc, 1);
    chk("s0_pass", 32'(p), 1);
    chk("s0_mask", 32'(m), 0);
    @(posedge clk); #1;
    chk("s0_no_restart", 32'(busy0), 0);

    // Start held high: done repeats every 27 cycles.
    start0 = 1'b1;
    t0 = 0;
    n = 0;
    for (int c = 0; c < 200 && n < 3; c++) begin
      @(posedge clk); #1;
      if (done0) begin
        tdone[n] = c;
        n++;
      end
    end
    start0 = 1'b0;
    chk("held_done_cnt", n, 3);
    if (n == 3) begin
      chk("held_period1", tdone[1] - tdone[0], 27);
      chk("held_period2", tdone[2] - tdone[1], 27);
    end
    repeat (30) @(posedge clk);
    #1;
    chk("held_pass", 32'(pass0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
